// File: rtl/tinker_dmem_responder_if.sv
// tinker_dmem_responder_if: request/response bus between an initiator and the data-memory responder.
interface tinker_dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/tinker_dmem_responder.sv
// tinker_dmem_responder: fixed-latency byte-addressed memory serving one 8-byte load/store at a time.
// Storage is eight byte-wide banks, so any unaligned access touches each bank exactly once.
module tinker_dmem_responder #(
    parameter int MEM_BYTES = 524288,
    parameter int LATENCY   = 2
) (
    input logic                    clk,
    input logic                    reset,
    tinker_dmem_responder_if.slave bus
);
    localparam int          ROWS = MEM_BYTES / 8;
    localparam int          RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int          AW   = RW + 3;
    localparam logic [63:0] LAST = 64'(MEM_BYTES - 8);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      r_state, w_next;
    logic [3:0]  r_cnt;
    logic        r_we, r_err;
    logic [63:0] r_addr, r_wdata, r_rdata, w_load;
    logic [7:0]  w_rd [8];
    logic        w_access, w_in_range;

    assign w_access   = (r_state == WAIT) && (r_cnt == '0);
    assign w_in_range = r_addr <= LAST;

    // Bank b holds byte k of the access where (addr + k) mod 8 == b.
    for (genvar b = 0; b < 8; b++) begin : g_bank
        logic [7:0]    r_mem [ROWS];
        logic [2:0]    w_k;
        logic [RW-1:0] w_row;
        assign w_k     = 3'(b) - r_addr[2:0];
        assign w_row   = RW'((r_addr[AW-1:0] + AW'(w_k)) >> 3);
        assign w_rd[b] = r_mem[w_row];
        always_ff @(posedge clk)
            if (w_access && r_we && w_in_range) r_mem[w_row] <= r_wdata[{w_k, 3'b000} +: 8];
    end

    always_comb begin
        w_load = '0;
        for (int k = 0; k < 8; k++) w_load[8*k +: 8] = w_rd[3'(k) + r_addr[2:0]];
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = bus.req_valid ? WAIT : IDLE;
            WAIT:    w_next = (r_cnt == '0) ? RESP : WAIT;
            RESP:    w_next = bus.rsp_ready ? IDLE : RESP;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            if (r_state == IDLE && bus.req_valid) begin
                r_we    <= bus.req_we;
                r_addr  <= bus.req_addr;
                r_wdata <= bus.req_wdata;
                r_cnt   <= 4'(LATENCY - 1);
            end else if (r_state == WAIT && r_cnt != '0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_access) begin
                r_rdata <= (!r_we && w_in_range) ? w_load : '0;
                r_err   <= !w_in_range;
            end
        end
    end

    assign bus.req_ready = r_state == IDLE;
    assign bus.rsp_valid = r_state == RESP;
    assign bus.rsp_rdata = (r_state == RESP) ? r_rdata : '0;
    assign bus.rsp_err   = (r_state == RESP) && r_err;
endmodule

// File: tb/tb_tinker_dmem_responder.sv
// tb_tinker_dmem_responder: randomized and directed traffic against a byte-level memory model,
// plus LATENCY=1 and LATENCY=15 instances on a small store.
module tb_tinker_dmem_responder;
    localparam int MEMB  = 524288;
    localparam int LAT   = 2;
    localparam int SMALL = 64;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    tinker_dmem_responder_if bus ();
    tinker_dmem_responder_if bus1 ();
    tinker_dmem_responder_if bus15 ();

    tinker_dmem_responder #(.MEM_BYTES(MEMB),  .LATENCY(LAT)) dut   (.clk(clk), .reset(reset), .bus(bus));
    tinker_dmem_responder #(.MEM_BYTES(SMALL), .LATENCY(1))   dut1  (.clk(clk), .reset(reset), .bus(bus1));
    tinker_dmem_responder #(.MEM_BYTES(SMALL), .LATENCY(15))  dut15 (.clk(clk), .reset(reset), .bus(bus15));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: one outstanding request, access performed LAT edges after acceptance.
    logic [7:0]      mm [longint unsigned];
    bit              busy = 0, have_rsp = 0;
    int              cyc = 0, acc = 0;
    logic            m_we, e_err;
    logic [63:0]     m_addr, m_wdata, e_rd, e_mask;
    longint unsigned ma;

    initial forever begin
        @(posedge clk or negedge reset);
        if (!reset) begin
            busy     = 0;
            have_rsp = 0;
        end else begin
            cyc++;
            if (!busy) begin
                if (bus.req_valid) begin
                    busy    = 1;
                    acc     = cyc;
                    m_we    = bus.req_we;
                    m_addr  = bus.req_addr;
                    m_wdata = bus.req_wdata;
                end
            end else if (have_rsp) begin
                if (bus.rsp_ready) begin
                    busy     = 0;
                    have_rsp = 0;
                end
            end else if (cyc - acc == LAT) begin
                e_err  = m_addr > 64'(MEMB - 8);
                e_rd   = '0;
                e_mask = '0;
                if (!e_err) begin
                    for (int k = 0; k < 8; k++) begin
                        ma = m_addr + 64'(k);
                        if (m_we) mm[ma] = m_wdata[8*k +: 8];
                        else if (mm.exists(ma)) begin
                            e_rd[8*k +: 8]   = mm[ma];
                            e_mask[8*k +: 8] = 8'hFF;
                        end
                    end
                end
                if (m_we || e_err) e_mask = '1;
                have_rsp = 1;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        chk("req_ready", bus.req_ready, 64'(!busy));
        chk("rsp_valid", bus.rsp_valid, 64'(have_rsp));
        if (have_rsp) begin
            chk("rsp_rdata", bus.rsp_rdata & e_mask, e_rd & e_mask);
            chk("rsp_err", bus.rsp_err, e_err);
        end else begin
            chk("idle_rdata", bus.rsp_rdata, 0);
            chk("idle_err", bus.rsp_err, 0);
        end
    end

    // mode 0: quiet, 1: random noise on ignored inputs, 2: hold req_valid high during backpressure
    task automatic txn(input logic we, input logic [63:0] a, input logic [63:0] d, input int hold,
                       input int mode, output logic [63:0] rd, output logic er);
        int n = 0;
        @(negedge clk); #1;
        chk("accept_ready", bus.req_ready, 1);
        bus.req_valid = 1; bus.req_we = we; bus.req_addr = a; bus.req_wdata = d;
        @(posedge clk); #1;
        bus.req_valid = 0;
        while (!bus.rsp_valid && n < 40) begin
            if (mode == 1) begin
                bus.rsp_ready = 1'($urandom);
                bus.req_valid = 1'($urandom);
                bus.req_addr  = {$urandom, $urandom};
            end
            @(posedge clk); #1;
            n++;
        end
        chk("latency", n, LAT);
        bus.rsp_ready = 0;
        bus.req_valid = (mode == 2);
        rd = bus.rsp_rdata;
        er = bus.rsp_err;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", bus.rsp_valid, 1);
            chk("hold_rdata", bus.rsp_rdata, rd);
            chk("hold_err", bus.rsp_err, er);
            chk("hold_ready", bus.req_ready, 0);
            if (mode == 1) bus.req_valid = 1'($urandom);
        end
        bus.rsp_ready = 1;
        bus.req_valid = 0;
        @(posedge clk); #1;
        bus.rsp_ready = 0;
        chk("after_hs_valid", bus.rsp_valid, 0);
        chk("after_hs_ready", bus.req_ready, 1);
    endtask

    task automatic lat_pair(input logic we, input logic [63:0] a, input logic [63:0] d,
                            input logic [63:0] exp_rd, input logic exp_err);
        int l1 = 0, l15 = 0;
        @(negedge clk); #1;
        bus1.req_valid  = 1; bus1.req_we  = we; bus1.req_addr  = a; bus1.req_wdata  = d;
        bus15.req_valid = 1; bus15.req_we = we; bus15.req_addr = a; bus15.req_wdata = d;
        @(posedge clk); #1;
        bus1.req_valid  = 0;
        bus15.req_valid = 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (l1 == 0 && bus1.rsp_valid) begin
                l1 = n;
                chk("l1_rdata", bus1.rsp_rdata, exp_rd);
                chk("l1_err", bus1.rsp_err, exp_err);
            end
            if (l15 == 0 && bus15.rsp_valid) begin
                l15 = n;
                chk("l15_rdata", bus15.rsp_rdata, exp_rd);
                chk("l15_err", bus15.rsp_err, exp_err);
            end
        end
        chk("lat1", l1, 1);
        chk("lat15", l15, 15);
        bus1.rsp_ready  = 1;
        bus15.rsp_ready = 1;
        @(posedge clk); #1;
        bus1.rsp_ready  = 0;
        bus15.rsp_ready = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] rd, a;
        logic        er;
        int          r;
        bus.req_valid   = 0; bus.req_we   = 0; bus.req_addr   = '0; bus.req_wdata   = '0; bus.rsp_ready   = 0;
        bus1.req_valid  = 0; bus1.req_we  = 0; bus1.req_addr  = '0; bus1.req_wdata  = '0; bus1.rsp_ready  = 0;
        bus15.req_valid = 0; bus15.req_we = 0; bus15.req_addr = '0; bus15.req_wdata = '0; bus15.rsp_ready = 0;
        #1 reset = 0;
        #2;
        chk("rst_req_ready", bus.req_ready, 1);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 0);
        chk("rst_rsp_err", bus.rsp_err, 0);
        repeat (3) @(negedge clk);
        #2 reset = 1;

        lat_pair(1, 64'd8,  64'h0123456789ABCDEF, 64'h0, 0);
        lat_pair(0, 64'd8,  64'h0,                64'h0123456789ABCDEF, 0);
        lat_pair(0, 64'd57, 64'h0,                64'h0, 1);
        lat_pair(1, 64'd56, 64'hFEDCBA9876543210, 64'h0, 0);
        lat_pair(0, 64'd56, 64'h0,                64'hFEDCBA9876543210, 0);

        txn(1, 64'h2000, 64'h1122334455667788, 0, 0, rd, er);
        chk("st2000_rdata", rd, 0);
        chk("st2000_err", er, 0);
        txn(0, 64'h2000, 64'h0, 0, 0, rd, er);
        chk("ld2000_rdata", rd, 64'h1122334455667788);
        chk("ld2000_byte0", rd[7:0], 8'h88);
        chk("ld2000_err", er, 0);

        txn(1, 64'h1000, 64'h0706050403020100, 0, 0, rd, er);
        txn(1, 64'h1003, 64'hAABBCCDDEEFF0011, 1, 0, rd, er);
        txn(0, 64'h1003, 64'h0, 0, 0, rd, er);
        chk("ld1003_rdata", rd, 64'hAABBCCDDEEFF0011);
        txn(0, 64'h1000, 64'h0, 0, 0, rd, er);
        chk("ld1000_rdata", rd, 64'hDDEEFF0011020100);
        chk("ld1000_low3", rd[23:0], 24'h020100);

        txn(0, 64'h7FFF9, 64'h0, 0, 0, rd, er);
        chk("oor_ld_rdata", rd, 0);
        chk("oor_ld_err", er, 1);
        txn(1, 64'h7FFF8, 64'h5A5A5A5A12345678, 0, 0, rd, er);
        chk("edge_st_err", er, 0);
        txn(1, 64'hFFFFFFFFFFFFFFF8, 64'hDEADDEADDEADDEAD, 0, 0, rd, er);
        chk("oor_st_err", er, 1);
        chk("oor_st_rdata", rd, 0);
        txn(0, 64'h7FFF8, 64'h0, 0, 0, rd, er);
        chk("edge_ld_rdata", rd, 64'h5A5A5A5A12345678);
        chk("edge_ld_err", er, 0);

        txn(0, 64'h2000, 64'h0, 5, 2, rd, er);
        chk("bp_rdata", rd, 64'h1122334455667788);

        txn(1, 64'h3000, 64'hCAFEF00DDEADBEEF, 0, 0, rd, er);
        @(negedge clk); #1;
        bus.req_valid = 1; bus.req_we = 1; bus.req_addr = 64'h3000; bus.req_wdata = 64'h0;
        @(posedge clk); #1;
        bus.req_valid = 0;
        @(negedge clk); #2;
        reset = 0;
        #1;
        chk("wait_rst_ready", bus.req_ready, 1);
        chk("wait_rst_valid", bus.rsp_valid, 0);
        @(negedge clk); #2;
        reset = 1;
        txn(0, 64'h3000, 64'h0, 0, 0, rd, er);
        chk("ld3000_after_rst", rd, 64'hCAFEF00DDEADBEEF);

        for (int t = 0; t < 200; t++) begin
            r = int'($urandom_range(0, 7));
            a = (r == 0) ? 64'(MEMB - 16 + int'($urandom_range(0, 23))) :
                (r == 1) ? {$urandom, $urandom} : 64'($urandom_range(16'h4000, 16'h403F));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            txn(1'($urandom), a, {$urandom, $urandom}, int'($urandom_range(0, 3)), 1, rd, er);
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
